// File: rtl/sc_stream_decoder_if.sv
// Stream interface for the stochastic-to-binary decoder.
// Master drives samples in, slave reports window totals.
interface sc_stream_decoder_if #(
  parameter int LANES = 4,
  parameter int OUT_W = 9
);
  logic             en_in;
  logic [LANES-1:0] seq;
  logic [OUT_W-1:0] result;
  logic             en_out;
  logic             busy;

  modport master (
    output en_in,
    output seq,
    input  result,
    input  en_out,
    input  busy
  );

  modport slave (
    input  en_in,
    input  seq,
    output result,
    output en_out,
    output busy
  );
endinterface

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: popcounts LANES streams over a
// window of LEN valid samples and reports the total.
module sc_stream_decoder #(
  parameter int LANES = 4,
  parameter int LEN   = 64,
  parameter int CNT_W = 7,
  parameter int OUT_W = 9
) (
  input  logic clk,
  input  logic rst,
  sc_stream_decoder_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  if ((2 ** OUT_W) <= (LANES * LEN)) begin : g_bad_out_w
    $error("OUT_W too small for LANES*LEN");
  end
  if ((2 ** CNT_W) <= LEN) begin : g_bad_cnt_w
    $error("CNT_W too small to hold LEN");
  end

  logic [0:0]       r_state;
  logic [OUT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_result;
  logic             r_en_out;

  logic [LANES-1:0] w_seq;
  logic [OUT_W-1:0] w_pop;
  logic [OUT_W-1:0] w_sum;
  logic             w_last;

  // Mask seq with en_in so an idle bus value never reaches the adder.
  assign w_seq = bus.en_in ? bus.seq : '0;

  // Popcount of the current sample.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pop = w_pop + OUT_W'(w_seq[i]);
    end
  end

  assign w_sum  = r_acc + w_pop;
  assign w_last = bus.en_in && (r_cnt == LAST);

  // Window accumulation, close and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_en_out <= 1'b0;
    end else begin
      r_en_out <= w_last;
      if (w_last) begin
        r_result <= w_sum;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_state  <= S_IDLE;
      end else if (bus.en_in) begin
        r_acc    <= w_sum;
        r_cnt    <= r_cnt + CNT_W'(1);
        r_state  <= S_ACC;
      end
    end
  end

  assign bus.result = r_result;
  assign bus.en_out = r_en_out;
  assign bus.busy   = (r_state == S_ACC);

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Bench for sc_stream_decoder: directed windows, expected
// totals queued by stimulus and checked by a monitor.
module tb_sc_stream_decoder;

  localparam int LANES = 4;
  localparam int LEN   = 64;
  localparam int OUT_W = 9;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  sc_stream_decoder_if #(.LANES(LANES), .OUT_W(OUT_W)) bus ();

  sc_stream_decoder #(
    .LANES(LANES), .LEN(LEN), .CNT_W(7), .OUT_W(OUT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one bus cycle just after the active edge.
  task automatic drive(input logic en, input logic [LANES-1:0] s);
    @(posedge clk);
    #1;
    bus.en_in = en;
    bus.seq   = s;
  endtask

  // Drive a valid sample; push the expected total on the last one.
  task automatic sample(input logic [LANES-1:0] s, input bit last,
                        input int total);
    drive(1'b1, s);
    if (last) begin
      exp_t e;
      e.val = total;
      e.cyc = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic window(input logic [LANES-1:0] s, input int total);
    for (int i = 0; i < LEN; i++) sample(s, i == LEN - 1, total);
  endtask

  // Monitor: every en_out pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.en_out) begin
      if (sb.size() == 0) begin
        chk("unexpected en_out", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", int'(bus.result), e.val);
        chk("en_out cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    cyc       = 0;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.en_in = 1'b0;
    bus.seq   = '0;
    repeat (2) @(negedge clk);
    chk("reset result", int'(bus.result), 0);
    chk("reset en_out", int'(bus.en_out), 0);
    chk("reset busy", int'(bus.busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1) all ones
    window(4'b1111, 256);
    // 2) all zeros then lane 0 only
    window(4'b0000, 0);
    window(4'b0001, 64);
    // 3) lane 0 alternating, lanes 1-3 high
    for (int i = 0; i < LEN; i++)
      sample({3'b111, (i % 2 == 0)}, i == LEN - 1, 224);
    drive(1'b0, '0);
    @(negedge clk);
    chk("idle busy", int'(bus.busy), 0);

    // 4) gap in the middle of a window
    for (int i = 0; i < 32; i++) sample(4'b1111, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 'x);
      @(negedge clk);
      chk("gap busy", int'(bus.busy), 1);
      chk("gap en_out", int'(bus.en_out), 0);
    end
    for (int i = 0; i < 32; i++) sample(4'b1111, i == 31, 256);

    // 5) back-to-back windows
    window(4'b1111, 256);
    window(4'b0011, 128);
    drive(1'b0, '0);

    // 6) reset mid-window
    for (int i = 0; i < 20; i++) sample(4'b1111, 0, 0);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.en_in = 1'b0;
    @(negedge clk);
    chk("mid rst result", int'(bus.result), 0);
    chk("mid rst en_out", int'(bus.en_out), 0);
    chk("mid rst busy", int'(bus.busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    window(4'b0001, 64);
    drive(1'b0, '0);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);
    chk("final result hold", int'(bus.result), 64);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
